// File: rtl/shift194_seq_if.sv
// Signal bundle between the job source, the sequencer and the downstream
// 74HC194-style shift register (mode, serial, parallel and feedback lines).
interface shift194_seq_if #(
    parameter int CNT_W = 3
);
    logic             START;
    logic [0:3]       DATA;
    logic             DIR;
    logic             RING;
    logic             FILL;
    logic [CNT_W-1:0] NSHIFT;
    logic             PAUSE;
    logic [0:3]       Q;
    logic [1:0]       S;
    logic [1:0]       D;
    logic [0:3]       PIN;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, DATA, DIR, RING, FILL, NSHIFT, PAUSE, Q,
        input  S, D, PIN, BUSY, DONE
    );

    modport slave (
        input  START, DATA, DIR, RING, FILL, NSHIFT, PAUSE, Q,
        output S, D, PIN, BUSY, DONE
    );
endinterface

// File: rtl/shift194_seq.sv
// Job sequencer for a 4-bit universal shift register: one parallel load,
// then NSHIFT shift cycles (pausable), then a one-cycle DONE pulse.
module shift194_seq #(
    parameter int CNT_W = 3
) (
    input  logic          CLK,
    input  logic          MR_N,
    shift194_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] nshift_q, nshift_d;
    logic [0:3]       data_q, data_d;
    logic             dir_q, dir_d;
    logic             ring_q, ring_d;
    logic             fill_q, fill_d;
    logic [1:0]       s_q, s_d;
    logic [0:3]       pin_q, pin_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            nshift_q <= '0;
            data_q   <= '0;
            dir_q    <= 1'b0;
            ring_q   <= 1'b0;
            fill_q   <= 1'b0;
            s_q      <= 2'b00;
            pin_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            nshift_q <= nshift_d;
            data_q   <= data_d;
            dir_q    <= dir_d;
            ring_q   <= ring_d;
            fill_q   <= fill_d;
            s_q      <= s_d;
            pin_q    <= pin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        nshift_d = nshift_q;
        data_d   = data_q;
        dir_d    = dir_q;
        ring_d   = ring_q;
        fill_d   = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    data_d   = bus.DATA;
                    dir_d    = bus.DIR;
                    ring_d   = bus.RING;
                    fill_d   = bus.FILL;
                    nshift_d = bus.NSHIFT;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (nshift_q != '0) begin
                    cnt_d   = nshift_q;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                // Count only edges where the register really shifted, so a pause never drops or adds a shift.
                if (s_q[1]) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs describe the cycle that follows this edge.
        s_d = 2'b00;
        case (state_d)
            ST_LOAD:  s_d = 2'b01;
            ST_SHIFT: s_d = bus.PAUSE ? 2'b00 : {1'b1, dir_d};
            default:  s_d = 2'b00;
        endcase
        pin_d  = data_d;
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign bus.S    = s_q;
    assign bus.PIN  = pin_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

    // Serial inputs follow Q live so rotation feeds back the bit leaving this cycle.
    assign bus.D[0] = ring_q ? bus.Q[0] : fill_q;
    assign bus.D[1] = ring_q ? bus.Q[3] : fill_q;

endmodule

// File: tb/tb_shift194_seq.sv
// Randomized bench for shift194_seq driving a behavioural 74HC194; expected
// register contents come from closed-form rotate/shift arithmetic.
module tb_shift194_seq;

    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic mr_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [0:3] q_reg;

    shift194_seq_if #(.CNT_W(CNT_W)) bus();

    assign bus.Q = q_reg;

    shift194_seq #(.CNT_W(CNT_W)) dut (
        .CLK  (clk),
        .MR_N (mr_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register that the sequencer controls.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            q_reg <= '0;
        end else begin
            case (bus.S)
                2'b01:   q_reg <= bus.PIN;
                2'b10:   q_reg <= {q_reg[1], q_reg[2], q_reg[3], bus.D[0]};
                2'b11:   q_reg <= {bus.D[1], q_reg[0], q_reg[1], q_reg[2]};
                default: q_reg <= q_reg;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Nibble packed with Q[0] as MSB: toward bit 0 is a left shift, toward bit 3 a right shift.
    function automatic logic [3:0] model_q(input logic [3:0] n, input logic dir,
                                           input logic ring, input logic fill, input int k);
        int v, r, kk;
        v = int'(n);
        if (ring) begin
            kk = k % 4;
            if (!dir) r = (v << kk) | (v >> (4 - kk));
            else      r = (v >> kk) | (v << (4 - kk));
        end else if (k >= 4) begin
            r = fill ? 15 : 0;
        end else if (!dir) begin
            r = (v << k) | (fill ? ((1 << k) - 1) : 0);
        end else begin
            r = (v >> k) | (fill ? (15 << (4 - k)) : 0);
        end
        return 4'(r & 15);
    endfunction

    task automatic run_job(input logic [3:0] data, input logic dir, input logic ring,
                           input logic fill, input int n, input logic [31:0] pmask,
                           input logic poke);
        logic [3:0] exp_q;
        logic [1:0] exp_s, exp_d;
        logic       last_pause;
        int         k, rem, step, budget;

        @(negedge clk);
        bus.DATA   = data;
        bus.DIR    = dir;
        bus.RING   = ring;
        bus.FILL   = fill;
        bus.NSHIFT = CNT_W'(n);
        bus.PAUSE  = 1'b0;
        bus.START  = 1'b1;
        @(posedge clk); #1;
        check("load_s",    32'(bus.S),    32'b01);
        check("load_busy", 32'(bus.BUSY), 32'd1);
        check("load_done", 32'(bus.DONE), 32'd0);
        check("load_pin",  32'(bus.PIN),  32'(data));

        @(negedge clk);
        step       = 0;
        bus.PAUSE  = pmask[0];
        last_pause = pmask[0];
        bus.START  = poke;
        if (poke) begin
            bus.DATA   = ~data;
            bus.DIR    = ~dir;
            bus.RING   = ~ring;
            bus.FILL   = ~fill;
            bus.NSHIFT = CNT_W'(n + 3);
        end
        @(posedge clk); #1;
        check("q_load", 32'(q_reg), 32'(data));

        k = 0;
        rem = n;
        budget = 0;
        while (rem > 0 && budget < 100) begin
            exp_q = model_q(data, dir, ring, fill, k);
            exp_s = last_pause ? 2'b00 : {1'b1, dir};
            exp_d = ring ? {exp_q[0], exp_q[3]} : {fill, fill};
            check("shift_s",    32'(bus.S),    32'(exp_s));
            check("shift_d",    32'(bus.D),    32'(exp_d));
            check("shift_busy", 32'(bus.BUSY), 32'd1);
            check("shift_done", 32'(bus.DONE), 32'd0);
            @(negedge clk);
            step++;
            bus.PAUSE = (step < 32) ? pmask[step] : 1'b0;
            @(posedge clk); #1;
            if (!last_pause) begin
                rem--;
                k++;
            end
            last_pause = bus.PAUSE;
            budget++;
            check("shift_q", 32'(q_reg), 32'(model_q(data, dir, ring, fill, k)));
        end
        check("shifts_left", 32'(rem), 32'd0);

        check("done_pulse", 32'(bus.DONE), 32'd1);
        check("done_busy",  32'(bus.BUSY), 32'd0);
        check("done_s",     32'(bus.S),    32'b00);
        check("done_q",     32'(q_reg),    32'(model_q(data, dir, ring, fill, n)));

        @(negedge clk);
        bus.PAUSE = 1'b0;
        @(posedge clk); #1;
        check("idle_done", 32'(bus.DONE), 32'd0);
        check("idle_busy", 32'(bus.BUSY), 32'd0);
        check("idle_s",    32'(bus.S),    32'b00);
        check("idle_q",    32'(q_reg),    32'(model_q(data, dir, ring, fill, n)));
        @(negedge clk);
        bus.START = 1'b0;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        bus.DATA   = 4'b1000;
        bus.DIR    = 1'b0;
        bus.RING   = 1'b1;
        bus.FILL   = 1'b0;
        bus.NSHIFT = CNT_W'(4);
        bus.PAUSE  = 1'b0;
        bus.START  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.START = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("rst_pre_q", 32'(q_reg), 32'b0001);
        @(negedge clk);
        mr_n = 1'b0;
        #1;
        check("rst_s",    32'(bus.S),    32'b00);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_done", 32'(bus.DONE), 32'd0);
        check("rst_q",    32'(q_reg),    32'd0);
        check("rst_d",    32'(bus.D),    32'b00);
        @(negedge clk);
        mr_n = 1'b1;
        @(posedge clk); #1;
        check("rst_idle_s",    32'(bus.S),    32'b00);
        check("rst_idle_busy", 32'(bus.BUSY), 32'd0);
    endtask

    initial begin
        logic [31:0] pmask;
        int          pct;

        mr_n       = 1'b1;
        bus.START  = 1'b0;
        bus.DATA   = '0;
        bus.DIR    = 1'b0;
        bus.RING   = 1'b0;
        bus.FILL   = 1'b0;
        bus.NSHIFT = '0;
        bus.PAUSE  = 1'b0;
        #1 mr_n = 1'b0;
        #2;
        check("reset_s",    32'(bus.S),    32'b00);
        check("reset_pin",  32'(bus.PIN),  32'd0);
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_done", 32'(bus.DONE), 32'd0);
        check("reset_d",    32'(bus.D),    32'b00);
        check("reset_q",    32'(q_reg),    32'd0);
        @(negedge clk);
        mr_n = 1'b1;

        run_job(4'b1010, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
        run_job(4'b1000, 1'b0, 1'b1, 1'b0, 3, 32'd0, 1'b0);
        run_job(4'b1000, 1'b0, 1'b1, 1'b0, 4, 32'd0, 1'b0);
        run_job(4'b0000, 1'b1, 1'b0, 1'b1, 2, 32'd0, 1'b0);
        run_job(4'b1000, 1'b0, 1'b1, 1'b0, 3, 32'b110, 1'b0);
        run_job(4'b1001, 1'b1, 1'b1, 1'b0, 5, 32'd0, 1'b1);
        reset_mid();
        run_job(4'b0110, 1'b1, 1'b1, 1'b0, 3, 32'd0, 1'b0);
        run_job(4'b1101, 1'b0, 1'b0, 1'b1, 7, 32'd0, 1'b0);

        repeat (40) begin
            pct = $urandom_range(0, 50);
            for (int i = 0; i < 32; i++) begin
                pmask[i] = ($urandom_range(0, 99) < pct);
            end
            run_job(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 7), pmask, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
